// File: rtl/setting_cursor_if.sv
// Binding handshake between the setting cursor and the key-map config logic.
// The master offers a (note, key) pair with cfg_valid; the slave accepts it with cfg_ready.
interface setting_cursor_if;
   logic       cfg_valid;
   logic [2:0] cfg_note;
   logic [2:0] cfg_key;
   logic       cfg_ready;

   modport master (output cfg_valid, output cfg_note, output cfg_key, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_note, input cfg_key, output cfg_ready);
endinterface

// File: rtl/setting_cursor_ctrl.sv
// Note-selection cursor for setting mode: navigates the seven note icons, arms a key binding,
// offers it to the key-map config, and produces the frame-synced highlight box for the overlay.
module setting_cursor_ctrl #(
   parameter int NOTE_NUM       = 7,
   parameter int X0             = 112,
   parameter int PITCH          = 64,
   parameter int Y0             = 416,
   parameter int BLINK_FRAMES   = 30,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic                      vga_clk,
   input  logic                      sys_rst_n,
   input  logic                      frame_start,
   input  logic                      btn_left,
   input  logic                      btn_right,
   input  logic                      btn_confirm,
   input  logic                      btn_cancel,
   input  logic                      key_valid,
   input  logic [2:0]                key_code,
   setting_cursor_if.master          cfg,
   output logic [2:0]                sel_note,
   output logic [9:0]                hl_x,
   output logic [9:0]                hl_y,
   output logic                      hl_on,
   output logic                      busy
);

   localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int TMO_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
   localparam logic [2:0]       LAST_NOTE = 3'(NOTE_NUM - 1);
   localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(BLINK_FRAMES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_FRAMES - 1);

   typedef enum logic [1:0] {BROWSE, ARMED, COMMIT} state_t;

   state_t            state, state_next;
   logic [2:0]        pend, pend_next;
   logic              latch_bind;
   logic              enter_armed;
   logic [BL_W-1:0]   blink_cnt;
   logic              blink_ph;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [9:0]        x_calc;

   assign hl_y   = 10'(Y0);
   assign x_calc = 10'(X0 + PITCH * int'(pend));

   // Confirm outranks navigation; in ARMED a key press outranks cancel, which outranks timeout.
   always_comb begin
      state_next  = state;
      pend_next   = pend;
      latch_bind  = 1'b0;
      enter_armed = 1'b0;
      case (state)
         BROWSE: begin
            if (btn_confirm) begin
               state_next  = ARMED;
               enter_armed = 1'b1;
            end else if (btn_right && !btn_left) begin
               pend_next = (pend == LAST_NOTE) ? 3'd0 : pend + 3'd1;
            end else if (btn_left && !btn_right) begin
               pend_next = (pend == 3'd0) ? LAST_NOTE : pend - 3'd1;
            end
         end
         ARMED: begin
            if (key_valid) begin
               state_next = COMMIT;
               latch_bind = 1'b1;
            end else if (btn_cancel) begin
               state_next = BROWSE;
            end else if (frame_start && tmo_cnt == TMO_LAST) begin
               state_next = BROWSE;
            end
         end
         COMMIT: begin
            if (cfg.cfg_valid && cfg.cfg_ready) state_next = BROWSE;
         end
         default: state_next = BROWSE;
      endcase
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= BROWSE;
         pend          <= 3'd0;
         busy          <= 1'b0;
         cfg.cfg_valid <= 1'b0;
         cfg.cfg_note  <= 3'd0;
         cfg.cfg_key   <= 3'd0;
      end else begin
         state         <= state_next;
         pend          <= pend_next;
         busy          <= (state_next != BROWSE);
         cfg.cfg_valid <= (state_next == COMMIT);
         if (latch_bind) begin
            cfg.cfg_note <= pend;
            cfg.cfg_key  <= key_code;
         end
      end
   end

   // Blink phase and timeout both count frames only while armed and restart on every arming.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
         tmo_cnt   <= '0;
      end else if (enter_armed) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
         tmo_cnt   <= '0;
      end else if (state == ARMED && frame_start) begin
         tmo_cnt <= tmo_cnt + 1'b1;
         if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Display registers sample the pre-edge cursor so the overlay never changes mid-frame.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel_note <= 3'd0;
         hl_x     <= 10'(X0);
         hl_on    <= 1'b1;
      end else if (frame_start) begin
         sel_note <= pend;
         hl_x     <= x_calc;
         hl_on    <= (state == ARMED) ? blink_ph : 1'b1;
      end
   end

endmodule

// File: tb/tb_setting_cursor_ctrl.sv
// Scoreboard bench for setting_cursor_ctrl: directed scenarios plus random pulses, checked against
// a frame-counting reference model of the cursor, arming, blink and binding handshake.
module tb_setting_cursor_ctrl;
   localparam int X0 = 112, PITCH = 64, Y0 = 416, BLINK = 30, TMO = 600, NN = 7;
   localparam int M_BROWSE = 0, M_ARMED = 1, M_COMMIT = 2;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       frame_start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_confirm = 1'b0, btn_cancel = 1'b0, key_valid = 1'b0;
   logic [2:0] key_code = 3'd0;
   logic [2:0] sel_note;
   logic [9:0] hl_x, hl_y;
   logic       hl_on, busy;

   setting_cursor_if cfg_if ();

   setting_cursor_ctrl dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
      .btn_left(btn_left), .btn_right(btn_right), .btn_confirm(btn_confirm),
      .btn_cancel(btn_cancel), .key_valid(key_valid), .key_code(key_code),
      .cfg(cfg_if.master), .sel_note(sel_note), .hl_x(hl_x), .hl_y(hl_y),
      .hl_on(hl_on), .busy(busy)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {int cyc; int sel; int x; int on; int valid; int busy; int note; int key;} exp_t;
   typedef struct {int note; int key;} bind_t;
   exp_t  sq[$];
   bind_t bq[$];

   int checks = 0, failures = 0, edge_cnt = 0;
   int m_mode, m_pend, m_frames, m_sel, m_x, m_on, m_valid, m_note, m_key;

   always @(posedge vga_clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_BROWSE; m_pend = 0; m_frames = 0;
      m_sel = 0; m_x = X0; m_on = 1;
      m_valid = 0; m_note = 0; m_key = 0;
   endfunction

   // One clock: apply pulses, advance the model across the coming edge, queue what it predicts.
   task automatic cyc(input bit fs, l, r, c, x, kv, input int kc, input bit rdy);
      exp_t  e;
      bind_t b;
      frame_start = fs; btn_left = l; btn_right = r; btn_confirm = c;
      btn_cancel = x; key_valid = kv; key_code = 3'(kc); cfg_if.cfg_ready = rdy;
      if (fs) begin
         m_sel = m_pend;
         m_x   = X0 + PITCH * m_pend;
         m_on  = (m_mode == M_ARMED) ? (((m_frames / BLINK) % 2 == 0) ? 1 : 0) : 1;
      end
      case (m_mode)
         M_BROWSE: begin
            if (c) begin
               m_mode = M_ARMED; m_frames = 0;
            end else if (r && !l) m_pend = (m_pend + 1) % NN;
            else if (l && !r) m_pend = (m_pend + NN - 1) % NN;
         end
         M_ARMED: begin
            if (kv) begin
               m_mode = M_COMMIT; m_valid = 1; m_note = m_pend; m_key = kc;
               b.note = m_pend; b.key = kc; bq.push_back(b);
            end else if (x) m_mode = M_BROWSE;
            else if (fs) begin
               if (m_frames == TMO - 1) m_mode = M_BROWSE;
               else m_frames++;
            end
         end
         default: begin
            if (rdy) begin
               m_mode = M_BROWSE; m_valid = 0;
            end
         end
      endcase
      e.cyc = edge_cnt + 1; e.sel = m_sel; e.x = m_x; e.on = m_on; e.valid = m_valid;
      e.busy = (m_mode != M_BROWSE) ? 1 : 0; e.note = m_note; e.key = m_key;
      sq.push_back(e);
      @(posedge vga_clk); #1;
      frame_start = 0; btn_left = 0; btn_right = 0; btn_confirm = 0;
      btn_cancel = 0; key_valid = 0; cfg_if.cfg_ready = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge vga_clk) begin : mon
      exp_t  e;
      bind_t b;
      logic [25:0] act, req;
      if (sys_rst_n && cfg_if.cfg_valid && cfg_if.cfg_ready) begin
         if (bq.size() == 0) chk("unexpected_bind", 1, 0);
         else begin
            b = bq.pop_front();
            chk("bind_note", 32'(cfg_if.cfg_note), 32'(b.note));
            chk("bind_key", 32'(cfg_if.cfg_key), 32'(b.key));
         end
      end
      while (sq.size() > 0 && sq[0].cyc <= edge_cnt) begin
         e = sq.pop_front();
         if (e.cyc != edge_cnt) chk("stale_expectation", 32'(e.cyc), 32'(edge_cnt));
         else begin
            act = {sel_note, hl_x, hl_y, hl_on, cfg_if.cfg_valid, busy};
            req = {3'(e.sel), 10'(e.x), 10'(Y0), 1'(e.on), 1'(e.valid), 1'(e.busy)};
            checks++;
            if (act !== req) begin
               failures++;
               $display("FAIL state@%0d actual sel=%0d x=%0d y=%0d on=%0b vld=%0b busy=%0b required sel=%0d x=%0d y=%0d on=%0d vld=%0d busy=%0d",
                        edge_cnt, sel_note, hl_x, hl_y, hl_on, cfg_if.cfg_valid, busy,
                        e.sel, e.x, Y0, e.on, e.valid, e.busy);
            end
            if (e.valid != 0)
               chk("offer_payload", 32'({cfg_if.cfg_note, cfg_if.cfg_key}), 32'({3'(e.note), 3'(e.key)}));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit saw_valid;
      cfg_if.cfg_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge vga_clk);
      #1;
      chk("rst_sel", 32'(sel_note), 0);
      chk("rst_hlx", 32'(hl_x), 32'(X0));
      chk("rst_hly", 32'(hl_y), 32'(Y0));
      chk("rst_hlon", 32'(hl_on), 1);
      chk("rst_valid", 32'(cfg_if.cfg_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      sys_rst_n = 1'b1;

      // three steps right, display only moves at frame_start
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 0);
      idle(1);
      chk("sel_before_frame", 32'(sel_note), 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("sel_after_frame", 32'(sel_note), 3);
      chk("hlx_after_frame", 32'(hl_x), 304);
      chk("hlon_browse", 32'(hl_on), 1);

      // wrap both directions, simultaneous left+right holds
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_left_sel", 32'(sel_note), 6);
      chk("wrap_left_hlx", 32'(hl_x), 496);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_right_sel", 32'(sel_note), 0);

      // bind note 2 to key 5 with a slow consumer
      repeat (2) cyc(0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      chk("armed_busy", 32'(busy), 1);
      chk("armed_no_valid", 32'(cfg_if.cfg_valid), 0);
      cyc(0, 0, 0, 0, 0, 1, 5, 0);
      for (int i = 0; i < 4; i++) begin
         chk("commit_valid", 32'(cfg_if.cfg_valid), 1);
         chk("commit_note", 32'(cfg_if.cfg_note), 2);
         chk("commit_key", 32'(cfg_if.cfg_key), 5);
         cyc(0, 0, (i == 1), 0, (i == 2), 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("handshake_valid", 32'(cfg_if.cfg_valid), 0);
      chk("handshake_busy", 32'(busy), 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("pend_after_bind", 32'(sel_note), 2);

      // blink and timeout
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      saw_valid = 1'b0;
      for (int f = 1; f <= TMO; f++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0);
         saw_valid |= cfg_if.cfg_valid;
         if (f == 1 || f == 30) chk($sformatf("blink_on_f%0d", f), 32'(hl_on), 1);
         if (f == 31 || f == 60) chk($sformatf("blink_off_f%0d", f), 32'(hl_on), 0);
         if (f == 61) chk("blink_on_f61", 32'(hl_on), 1);
         if (f == TMO - 1) chk("armed_before_timeout", 32'(busy), 1);
         cyc(0, 0, 0, 0, 0, 0, 0, 0);
         saw_valid |= cfg_if.cfg_valid;
      end
      chk("timeout_browse", 32'(busy), 0);
      chk("timeout_no_valid", 32'(saw_valid), 0);

      // key beats cancel, commit ignores buttons, reset mid-commit
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 3, 0);
      chk("key_wins_valid", 32'(cfg_if.cfg_valid), 1);
      chk("key_wins_key", 32'(cfg_if.cfg_key), 3);
      cyc(0, 0, 1, 0, 1, 0, 0, 0);
      chk("commit_ignores_btn", 32'(cfg_if.cfg_valid), 1);
      @(negedge vga_clk); #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(cfg_if.cfg_valid), 0);
      chk("async_rst_sel", 32'(sel_note), 0);
      chk("async_rst_hlx", 32'(hl_x), 32'(X0));
      chk("async_rst_busy", 32'(busy), 0);
      model_reset();
      bq.delete();
      sq.delete();
      repeat (2) @(posedge vga_clk);
      #1;
      sys_rst_n = 1'b1;

      // random pulses against the model
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
             int'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge vga_clk); #1;
      chk("bind_queue_drained", 32'(bq.size()), 0);
      chk("state_queue_drained", 32'(sq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
